l4_layer_sequencer: RTL and testbench

Parametrised successor to the L4 layer counter. Steps a layer index under an enable, with a runtime-programmable layer count and four sequencing modes: wrap-up, wrap-down, bounce and one-shot. Adds a start/abort control FSM, a wrap pulse, a done flag and a saturating pass counter. Sits between the L4 readout controller (which drives start/en) and the per-layer address mux (which consumes layer and the boundary flags).

---
 rtl/l4_pkg.sv | 17 +
 rtl/l4_layer_sequencer.sv | 135 +++++++++++++
 tb/tb_l4_layer_sequencer.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/l4_pkg.sv
// Shared mode encodings and FSM state type for the L4 layer sequencer.
// Latency: none; this file holds types and constants only.
// Backpressure: none; no handshaking is defined here.
package l4_pkg;

  localparam logic [1:0] L4_MODE_WRAP_UP = 2'b00;
  localparam logic [1:0] L4_MODE_WRAP_DN = 2'b01;
  localparam logic [1:0] L4_MODE_BOUNCE  = 2'b10;
  localparam logic [1:0] L4_MODE_ONESHOT = 2'b11;

  typedef enum logic [1:0] {
    L4_SEQ_IDLE = 2'd0,
    L4_SEQ_RUN  = 2'd1,
    L4_SEQ_DONE = 2'd2
  } l4_seq_state_t;

endpackage

// File: rtl/l4_layer_sequencer.sv
// Steps a layer index over 0..top in one of four modes, with a start/abort FSM, wrap pulse and pass counter.
// Latency: a step requested by en in RUN shows on layer/dir/wrap one cycle later; start and abort also act in one cycle.
// Backpressure: none; en is a per-cycle advance request, ignored outside RUN, and there is no ready signal.
module l4_layer_sequencer
  import l4_pkg::*;
#(
  parameter int NLBITS  = 3,
  parameter int NLAYERS = 8,
  parameter int NCBITS  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic              en,
  input  logic [1:0]        mode,
  input  logic [NLBITS-1:0] top_cfg,
  output logic [NLBITS-1:0] layer,
  output logic              dir,
  output logic              top_l,
  output logic              bottom_l,
  output logic              wrap,
  output logic              busy,
  output logic              done,
  output logic [NCBITS-1:0] pass_count
);

  localparam logic [NLBITS-1:0] TOP_MAX = NLBITS'(NLAYERS - 1);
  localparam logic [NCBITS-1:0] PC_MAX  = {NCBITS{1'b1}};

  // Result of one enabled step: new position, pass completion, and end of a one-shot run.
  typedef struct packed {
    logic [NLBITS-1:0] layer;
    logic              dir;
    logic              wrap;
    logic              fin;
  } step_t;

  l4_seq_state_t     state;
  logic [1:0]        mode_lat;
  logic [NLBITS-1:0] top_lat;
  logic [NLBITS-1:0] top_clamp;
  step_t             nxt;

  // Next position for one enabled step. Bounds are top and 0, so arithmetic never wraps.
  function automatic step_t next_step(input logic [1:0] m, input logic [NLBITS-1:0] cur,
                                      input logic d, input logic [NLBITS-1:0] top);
    step_t r;
    r.layer = cur;
    r.dir   = d;
    r.wrap  = 1'b0;
    r.fin   = 1'b0;
    if (top == '0) begin
      // A single-layer range completes a pass on every step and never changes direction.
      r.layer = '0;
      r.dir   = 1'b0;
      r.wrap  = 1'b1;
      r.fin   = (m == L4_MODE_ONESHOT);
    end else begin
      case (m)
        L4_MODE_WRAP_UP: begin
          r.wrap  = (cur == top);
          r.layer = r.wrap ? '0 : cur + 1'b1;
        end
        L4_MODE_WRAP_DN: begin
          r.wrap  = (cur == '0);
          r.layer = r.wrap ? top : cur - 1'b1;
        end
        L4_MODE_BOUNCE: begin
          if (!d) begin
            r.dir   = (cur == top);
            r.layer = r.dir ? top - 1'b1 : cur + 1'b1;
          end else begin
            r.dir   = (cur != '0);
            r.layer = r.dir ? cur - 1'b1 : NLBITS'(1);
          end
          // The pass ends on the step that reaches 0 while still descending.
          r.wrap = r.dir && (r.layer == '0);
        end
        L4_MODE_ONESHOT: begin
          r.wrap  = (cur == top);
          r.fin   = r.wrap;
          r.layer = r.wrap ? cur : cur + 1'b1;
        end
        default: ;
      endcase
    end
    return r;
  endfunction

  // Clamp the requested top layer and precompute the step from the current position.
  always_comb begin
    top_clamp = (top_cfg > TOP_MAX) ? TOP_MAX : top_cfg;
    nxt       = next_step(mode_lat, layer, dir, top_lat);
  end

  // Control FSM and all registered outputs. Abort beats start, and start beats en.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= L4_SEQ_IDLE;
      layer      <= '0;
      dir        <= 1'b0;
      top_lat    <= TOP_MAX;
      mode_lat   <= L4_MODE_WRAP_UP;
      pass_count <= '0;
      wrap       <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (abort) begin
        state <= L4_SEQ_IDLE;
        layer <= '0;
        dir   <= 1'b0;
      end else if (start) begin
        state      <= L4_SEQ_RUN;
        mode_lat   <= mode;
        top_lat    <= top_clamp;
        pass_count <= '0;
        layer      <= (mode == L4_MODE_WRAP_DN) ? top_clamp : '0;
        dir        <= (mode == L4_MODE_WRAP_DN) && (top_clamp != '0);
      end else if ((state == L4_SEQ_RUN) && en) begin
        layer <= nxt.layer;
        dir   <= nxt.dir;
        wrap  <= nxt.wrap;
        if (nxt.wrap && (pass_count != PC_MAX)) pass_count <= pass_count + 1'b1;
        if (nxt.fin) state <= L4_SEQ_DONE;
      end
    end
  end

  assign top_l    = (layer != top_lat);
  assign bottom_l = (layer != '0);
  assign busy     = (state == L4_SEQ_RUN);
  assign done     = (state == L4_SEQ_DONE);

endmodule

// File: tb/tb_l4_layer_sequencer.sv
// Self-checking bench: fixed vector table, asynchronous reset check, then random traffic against a model.
// Latency: outputs are sampled 1 ns after each rising edge.
// Backpressure: none; inputs are driven on the falling edge.
module tb_l4_layer_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0, abort = 1'b0, en = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [2:0] top_cfg = 3'd0;

  logic [2:0] layer8, layer6;
  logic       dir8, top_l8, bottom_l8, wrap8, busy8, done8;
  logic       dir6, top_l6, bottom_l6, wrap6, busy6, done6;
  logic [1:0] pc8;
  logic [7:0] pc6;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  l4_layer_sequencer #(.NLBITS(3), .NLAYERS(8), .NCBITS(2)) dut8 (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .en(en), .mode(mode),
    .top_cfg(top_cfg), .layer(layer8), .dir(dir8), .top_l(top_l8), .bottom_l(bottom_l8),
    .wrap(wrap8), .busy(busy8), .done(done8), .pass_count(pc8));

  l4_layer_sequencer #(.NLBITS(3), .NLAYERS(6), .NCBITS(8)) dut6 (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .en(en), .mode(mode),
    .top_cfg(top_cfg), .layer(layer6), .dir(dir6), .top_l(top_l6), .bottom_l(bottom_l6),
    .wrap(wrap6), .busy(busy6), .done(done6), .pass_count(pc6));

  // ---------------- reference model ----------------
  // st: 0 idle, 1 run, 2 done. s counts enabled steps since start; the position follows from s.
  typedef struct packed {
    int st; int md; int top; int s; int passes; int wr;
  } mdl_t;

  mdl_t m8, m6;

  function automatic mdl_t mdl_rst(int nl);
    mdl_t r;
    r.st = 0; r.md = 0; r.top = nl - 1; r.s = 0; r.passes = 0; r.wr = 0;
    return r;
  endfunction

  function automatic mdl_t mdl_clk(mdl_t m, int nl, logic st, logic ab, logic e,
                                   logic [1:0] md, logic [2:0] cfg);
    mdl_t r;
    int ev;
    r = m;
    r.wr = 0;
    if (ab) begin
      r.st = 0; r.s = 0;
    end else if (st) begin
      r.st = 1; r.md = int'(md); r.s = 0; r.passes = 0;
      r.top = (int'(cfg) > nl - 1) ? nl - 1 : int'(cfg);
    end else if (m.st == 1 && e) begin
      r.s = m.s + 1;
      case (r.md)
        0, 1:    ev = ((r.s % (r.top + 1)) == 0) ? 1 : 0;
        2:       ev = (r.top == 0 || (r.s % (2 * r.top)) == 0) ? 1 : 0;
        default: ev = (r.s == r.top + 1) ? 1 : 0;
      endcase
      if (ev != 0) begin
        r.wr = 1;
        r.passes = r.passes + 1;
        if (r.md == 3) r.st = 2;
      end
    end
    return r;
  endfunction

  function automatic int mdl_layer(mdl_t m);
    int p;
    if (m.st == 0) return 0;
    case (m.md)
      0: return m.s % (m.top + 1);
      1: return m.top - (m.s % (m.top + 1));
      2: begin
        if (m.top == 0) return 0;
        p = m.s % (2 * m.top);
        return (p <= m.top) ? p : 2 * m.top - p;
      end
      default: return (m.s > m.top) ? m.top : m.s;
    endcase
  endfunction

  function automatic int mdl_dir(mdl_t m);
    int p;
    if (m.st == 0 || m.top == 0) return 0;
    if (m.md == 1) return 1;
    if (m.md != 2) return 0;
    p = m.s % (2 * m.top);
    return (p > m.top || (p == 0 && m.s > 0)) ? 1 : 0;
  endfunction

  // Model advances on the same edges as the DUTs.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m8 = mdl_rst(8);
      m6 = mdl_rst(6);
    end else begin
      m8 = mdl_clk(m8, 8, start, abort, en, mode, top_cfg);
      m6 = mdl_clk(m6, 6, start, abort, en, mode, top_cfg);
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cmp_all();
    int l;
    l = mdl_layer(m8);
    chk("r8.layer", 32'(layer8), 32'(l));
    chk("r8.dir", 32'(dir8), 32'(mdl_dir(m8)));
    chk("r8.wrap", 32'(wrap8), 32'(m8.wr));
    chk("r8.pass_count", 32'(pc8), 32'((m8.passes > 3) ? 3 : m8.passes));
    chk("r8.busy", 32'(busy8), 32'(m8.st == 1));
    chk("r8.done", 32'(done8), 32'(m8.st == 2));
    chk("r8.top_l", 32'(top_l8), 32'(l != m8.top));
    chk("r8.bottom_l", 32'(bottom_l8), 32'(l != 0));
    l = mdl_layer(m6);
    chk("r6.layer", 32'(layer6), 32'(l));
    chk("r6.dir", 32'(dir6), 32'(mdl_dir(m6)));
    chk("r6.wrap", 32'(wrap6), 32'(m6.wr));
    chk("r6.pass_count", 32'(pc6), 32'((m6.passes > 255) ? 255 : m6.passes));
    chk("r6.busy", 32'(busy6), 32'(m6.st == 1));
    chk("r6.done", 32'(done6), 32'(m6.st == 2));
    chk("r6.top_l", 32'(top_l6), 32'(l != m6.top));
    chk("r6.bottom_l", 32'(bottom_l6), 32'(l != 0));
  endtask

  // ---------------- vector table (checked on dut8) ----------------
  typedef struct {
    logic       st, ab, en;
    logic [1:0] md;
    logic [2:0] cfg;
    logic [2:0] lay;
    logic       dr, wr;
    logic [1:0] pc;
    logic       by, dn;
    logic [2:0] tp;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(logic st, logic ab, logic e, logic [1:0] md, logic [2:0] cfg,
                              logic [2:0] lay, logic dr, logic wr, logic [1:0] pc,
                              logic by, logic dn, logic [2:0] tp);
    vec_t v;
    v.st = st; v.ab = ab; v.en = e; v.md = md; v.cfg = cfg; v.lay = lay; v.dr = dr;
    v.wr = wr; v.pc = pc; v.by = by; v.dn = dn; v.tp = tp;
    tbl.push_back(v);
  endfunction

  initial begin
    // wrap-up, top 4
    add(1,0,0,0,4, 0,0,0,0,1,0,4);
    add(0,0,1,0,0, 1,0,0,0,1,0,4); add(0,0,1,0,0, 2,0,0,0,1,0,4);
    add(0,0,1,0,0, 3,0,0,0,1,0,4); add(0,0,1,0,0, 4,0,0,0,1,0,4);
    add(0,0,1,0,0, 0,0,1,1,1,0,4); add(0,0,1,0,0, 1,0,0,1,1,0,4);
    add(0,0,1,0,0, 2,0,0,1,1,0,4); add(0,0,1,0,0, 3,0,0,1,1,0,4);
    add(0,0,1,0,0, 4,0,0,1,1,0,4); add(0,0,1,0,0, 0,0,1,2,1,0,4);
    add(0,0,1,0,0, 1,0,0,2,1,0,4);
    // bounce, top 3
    add(1,0,0,2,3, 0,0,0,0,1,0,3);
    add(0,0,1,0,0, 1,0,0,0,1,0,3); add(0,0,1,0,0, 2,0,0,0,1,0,3);
    add(0,0,1,0,0, 3,0,0,0,1,0,3); add(0,0,1,0,0, 2,1,0,0,1,0,3);
    add(0,0,1,0,0, 1,1,0,0,1,0,3); add(0,0,1,0,0, 0,1,1,1,1,0,3);
    add(0,0,1,0,0, 1,0,0,1,1,0,3); add(0,0,1,0,0, 2,0,0,1,1,0,3);
    add(0,0,1,0,0, 3,0,0,1,1,0,3);
    // one-shot, top 2, en 1,0,1,1,1 then start+abort together
    add(1,0,0,3,2, 0,0,0,0,1,0,2);
    add(0,0,1,0,0, 1,0,0,0,1,0,2); add(0,0,0,0,0, 1,0,0,0,1,0,2);
    add(0,0,1,0,0, 2,0,0,0,1,0,2); add(0,0,1,0,0, 2,0,1,1,0,1,2);
    add(0,0,1,0,0, 2,0,0,1,0,1,2);
    add(1,1,0,1,5, 0,0,0,1,0,0,2);
    // wrap-down, top 7
    add(1,0,0,1,7, 7,1,0,0,1,0,7);
    add(0,0,1,0,0, 6,1,0,0,1,0,7); add(0,0,1,0,0, 5,1,0,0,1,0,7);
    add(0,0,1,0,0, 4,1,0,0,1,0,7); add(0,0,1,0,0, 3,1,0,0,1,0,7);
    add(0,0,1,0,0, 2,1,0,0,1,0,7); add(0,0,1,0,0, 1,1,0,0,1,0,7);
    add(0,0,1,0,0, 0,1,0,0,1,0,7); add(0,0,1,0,0, 7,1,1,1,1,0,7);
    // degenerate top 0 with 2-bit saturating counter
    add(1,0,0,0,0, 0,0,0,0,1,0,0);
    add(0,0,1,0,0, 0,0,1,1,1,0,0); add(0,0,1,0,0, 0,0,1,2,1,0,0);
    add(0,0,1,0,0, 0,0,1,3,1,0,0); add(0,0,1,0,0, 0,0,1,3,1,0,0);
    add(0,0,1,0,0, 0,0,1,3,1,0,0); add(0,0,1,0,0, 0,0,1,3,1,0,0);
    add(0,0,0,0,0, 0,0,0,3,1,0,0);
    // one-shot with top 0 finishes on the first step
    add(1,0,0,3,0, 0,0,0,0,1,0,0); add(0,0,1,0,0, 0,0,1,1,0,1,0);
    // start beats en; abort beats en; en ignored in IDLE
    add(1,0,1,2,5, 0,0,0,0,1,0,5); add(0,0,1,0,0, 1,0,0,0,1,0,5);
    add(0,1,1,2,5, 0,0,0,0,0,0,5); add(0,0,1,0,0, 0,0,0,0,0,0,5);
  end

  // ---------------- main sequence ----------------
  initial begin
    #12;
    chk("rst.layer", 32'(layer8), 32'd0);
    chk("rst.dir", 32'(dir8), 32'd0);
    chk("rst.wrap", 32'(wrap8), 32'd0);
    chk("rst.pass_count", 32'(pc8), 32'd0);
    chk("rst.busy", 32'(busy8), 32'd0);
    chk("rst.done", 32'(done8), 32'd0);
    chk("rst.top_l", 32'(top_l8), 32'd1);
    chk("rst.bottom_l", 32'(bottom_l8), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      start = tbl[i].st; abort = tbl[i].ab; en = tbl[i].en;
      mode = tbl[i].md; top_cfg = tbl[i].cfg;
      @(posedge clk);
      #1;
      chk($sformatf("tbl%0d.layer", i), 32'(layer8), 32'(tbl[i].lay));
      chk($sformatf("tbl%0d.dir", i), 32'(dir8), 32'(tbl[i].dr));
      chk($sformatf("tbl%0d.wrap", i), 32'(wrap8), 32'(tbl[i].wr));
      chk($sformatf("tbl%0d.pass_count", i), 32'(pc8), 32'(tbl[i].pc));
      chk($sformatf("tbl%0d.busy", i), 32'(busy8), 32'(tbl[i].by));
      chk($sformatf("tbl%0d.done", i), 32'(done8), 32'(tbl[i].dn));
      chk($sformatf("tbl%0d.top_l", i), 32'(top_l8), 32'(tbl[i].lay != tbl[i].tp));
      chk($sformatf("tbl%0d.bottom_l", i), 32'(bottom_l8), 32'(tbl[i].lay != 3'd0));
    end

    // Asynchronous reset in the middle of a run at layer 5 with one pass done.
    @(negedge clk);
    start = 1'b1; abort = 1'b0; en = 1'b0; mode = 2'b00; top_cfg = 3'd5;
    @(negedge clk);
    start = 1'b0; en = 1'b1;
    repeat (11) @(negedge clk);
    en = 1'b0;
    chk("mid.layer_before", 32'(layer8), 32'd5);
    chk("mid.pass_before", 32'(pc8), 32'd1);
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    chk("mid.layer", 32'(layer8), 32'd0);
    chk("mid.busy", 32'(busy8), 32'd0);
    chk("mid.pass_count", 32'(pc8), 32'd0);
    chk("mid.top_l", 32'(top_l8), 32'd1);
    chk("mid.bottom_l", 32'(bottom_l8), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Random traffic on both parameterisations against the model.
    for (int c = 0; c < 2500; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 299) == 0) begin
        reset = 1'b1;
        #1;
        cmp_all();
        reset = 1'b0;
      end
      start   = ($urandom_range(0, 15) == 0);
      abort   = ($urandom_range(0, 39) == 0);
      en      = ($urandom_range(0, 3) != 0);
      mode    = 2'($urandom_range(0, 3));
      top_cfg = 3'($urandom_range(0, 7));
      @(posedge clk);
      #1;
      cmp_all();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
